// File: rtl/snowbro2_dwnld_pkg.sv
// Shared types and helpers for the snowbro2 ROM download packer.
package snowbro2_dwnld_pkg;

  localparam int unsigned ADDR_W = 26;
  localparam int unsigned WADDR_W = 22;
  localparam int unsigned DATA_W = 16;

  localparam logic [1:0] MASK_LO   = 2'b10;
  localparam logic [1:0] MASK_HI   = 2'b01;
  localparam logic [1:0] MASK_WORD = 2'b00;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  typedef struct packed {
    logic [1:0]         ba;
    logic [WADDR_W-1:0] addr;
    logic [DATA_W-1:0]  data;
    logic [1:0]         mask;
  } fifo_entry_t;

  // Map one download byte onto a bank, word address and byte lane.
  function automatic fifo_entry_t decode_byte(input logic [ADDR_W-1:0] addr,
                                              input logic [7:0]        din,
                                              input logic [ADDR_W-1:0] ba1,
                                              input logic [ADDR_W-1:0] ba2,
                                              input logic [ADDR_W-1:0] ba3);
    fifo_entry_t e;
    logic [WADDR_W:0] off;
    if (addr < ba1) begin
      e.ba = 2'd0;
      off  = (WADDR_W+1)'(addr);
    end else if (addr < ba2) begin
      e.ba = 2'd1;
      off  = (WADDR_W+1)'(addr - ba1);
    end else if (addr < ba3) begin
      e.ba = 2'd2;
      off  = (WADDR_W+1)'(addr - ba2);
    end else begin
      e.ba = 2'd3;
      off  = (WADDR_W+1)'(addr - ba3);
    end
    e.addr = off[WADDR_W:1];
    if (off[0]) begin
      e.data = {din, 8'h00};
      e.mask = MASK_HI;
    end else begin
      e.data = {8'h00, din};
      e.mask = MASK_LO;
    end
    return e;
  endfunction

endpackage

// File: rtl/snowbro2_dwnld_fifo.sv
// Synchronous FIFO with simultaneous push/pop; caller must not push when full
// unless popping in the same cycle, and must not pop when empty.
module snowbro2_dwnld_fifo #(
  parameter int unsigned WIDTH = 42,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data_c,
  output logic                     full_c,
  output logic                     empty_c,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data_c = mem_q[rd_ptr_q];
  assign full_c    = (count_q == CW'(DEPTH));
  assign empty_c   = (count_q == '0);
  assign count     = count_q;

endmodule

// File: rtl/snowbro2_dwnld_packer.sv
// Byte-serial ROM download to SDRAM bank-write converter for snowbro2.
// Optional word packing of even/odd byte pairs: define SNOWBRO2_WORD_PACK_EN.
module snowbro2_dwnld_packer
  import snowbro2_dwnld_pkg::*;
#(
  parameter logic [25:0] BA1_START  = 26'h080000,
  parameter logic [25:0] BA2_START  = 26'h0A0000,
  parameter logic [25:0] BA3_START  = 26'h1A0000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        DOWNLOADING,
  input  logic [25:0] IOCTL_ADDR,
  input  logic [7:0]  IOCTL_DOUT,
  input  logic        IOCTL_WR,
  output logic [21:0] PROG_ADDR,
  output logic [15:0] PROG_DATA,
  output logic [1:0]  PROG_MASK,
  output logic [1:0]  PROG_BA,
  output logic        PROG_WE,
  input  logic        PROG_RDY,
  output logic        DWNLD_BUSY,
  output logic        OVERFLOW
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  fifo_entry_t   new_ent_c, push_ent_c, head_c;
  logic          wr_acc_c, dl_q, dl_rise_c;
  logic          push_req_c, push_ok_c, drop_c, pop_c;
  logic          full_c, empty_c;
  logic [CW-1:0] fifo_count;
  logic          pend_v_d;

  state_t        state_q, state_d;
  logic          we_q, we_d;
  logic [1:0]    ba_q, ba_d, mask_q, mask_d;
  logic [21:0]   addr_q, addr_d;
  logic [15:0]   data_q, data_d;
  logic          busy_q, busy_d, ovf_q, ovf_d;

  assign wr_acc_c  = IOCTL_WR & DOWNLOADING;
  assign dl_rise_c = DOWNLOADING & ~dl_q;
  assign new_ent_c = decode_byte(IOCTL_ADDR, IOCTL_DOUT, BA1_START, BA2_START, BA3_START);

`ifdef SNOWBRO2_WORD_PACK_EN
  fifo_entry_t pend_q, pend_d;
  logic        pend_v_q;
  logic        dl_fall_c;

  assign dl_fall_c = dl_q & ~DOWNLOADING;

  // Pending slot holds an even byte awaiting its partner, or an odd byte that
  // lost its turn to a flushed partner and must go out next cycle.
  always_comb begin
    pend_d     = pend_q;
    pend_v_d   = pend_v_q;
    push_req_c = 1'b0;
    push_ent_c = new_ent_c;
    if (wr_acc_c) begin
      if (pend_v_q && pend_q.mask == MASK_LO && new_ent_c.mask == MASK_HI &&
          pend_q.ba == new_ent_c.ba && pend_q.addr == new_ent_c.addr) begin
        push_req_c      = 1'b1;
        push_ent_c      = pend_q;
        push_ent_c.data = {new_ent_c.data[15:8], pend_q.data[7:0]};
        push_ent_c.mask = MASK_WORD;
        pend_v_d        = 1'b0;
      end else if (pend_v_q) begin
        push_req_c = 1'b1;
        push_ent_c = pend_q;
        pend_d     = new_ent_c;
      end else if (new_ent_c.mask == MASK_LO) begin
        pend_d   = new_ent_c;
        pend_v_d = 1'b1;
      end else begin
        push_req_c = 1'b1;
      end
    end else if (pend_v_q && (pend_q.mask == MASK_HI || dl_fall_c)) begin
      push_req_c = 1'b1;
      push_ent_c = pend_q;
      pend_v_d   = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pend_q   <= '0;
      pend_v_q <= 1'b0;
    end else begin
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
    end
  end
`else
  always_comb begin
    push_req_c = wr_acc_c;
    push_ent_c = new_ent_c;
    pend_v_d   = 1'b0;
  end
`endif

  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push_ok_c = push_req_c & (~full_c | pop_c);
  assign drop_c    = push_req_c & full_c & ~pop_c;

  snowbro2_dwnld_fifo #(
    .WIDTH($bits(fifo_entry_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (CLK),
    .rst      (RESET),
    .push     (push_ok_c),
    .pop      (pop_c),
    .wr_data  (push_ent_c),
    .rd_data_c(head_c),
    .full_c   (full_c),
    .empty_c  (empty_c),
    .count    (fifo_count)
  );

  // Write FSM and output registers; busy looks at next-cycle occupancy.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    ba_d    = ba_q;
    addr_d  = addr_q;
    data_d  = data_q;
    mask_d  = mask_q;
    pop_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty_c) begin
          pop_c   = 1'b1;
          we_d    = 1'b1;
          ba_d    = head_c.ba;
          addr_d  = head_c.addr;
          data_d  = head_c.data;
          mask_d  = head_c.mask;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (PROG_RDY) begin
          we_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = DOWNLOADING | pend_v_d | push_ok_c | (fifo_count > CW'(pop_c)) | we_d;
    ovf_d  = (dl_rise_c ? 1'b0 : ovf_q) | drop_c;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      ba_q    <= 2'd0;
      addr_q  <= '0;
      data_q  <= '0;
      mask_q  <= 2'b11;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
      dl_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      ba_q    <= ba_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
      dl_q    <= DOWNLOADING;
    end
  end

  assign PROG_WE    = we_q;
  assign PROG_BA    = ba_q;
  assign PROG_ADDR  = addr_q;
  assign PROG_DATA  = data_q;
  assign PROG_MASK  = mask_q;
  assign DWNLD_BUSY = busy_q;
  assign OVERFLOW   = ovf_q;

endmodule
